// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad scanner.
// Used by the scan FSM to translate (row, one-hot column) into a hex code.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } scan_state_t;

   localparam logic [3:0] ROW_INIT = 4'b0001;

   function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                             input logic [3:0] col_onehot);
      logic [1:0] col;
      logic [3:0] code;
      col  = 2'd0;
      code = 4'h0;
      case (col_onehot)
         4'b0010: col = 2'd1;
         4'b0100: col = 2'd2;
         4'b1000: col = 2'd3;
         default: col = 2'd0;
      endcase
      case ({row_idx, col})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'hE;
         4'hD: code = 4'h0;
         4'hE: code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_scan_fsm_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs.
// Latency 2 clk cycles; no flow control.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan_fsm.sv
// Row-scan, debounce and key-accept controller for the 4x4 keypad.
// key_valid lands DEBOUNCE_CYCLES edges after PRESS_DB entry; no backpressure, one pulse per press.
module keypad_scan_fsm
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       stop,
   input  logic [3:0] cout,
   output logic [3:0] rows,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held
);

   localparam int DW  = (SCAN_DIV > 1)        ? $clog2(SCAN_DIV)        : 1;
   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);

   logic [4:0]     w_sync;
   logic           w_stop_s;
   logic [3:0]     w_cout_s;
   logic [3:0]     w_rows_rot;
   logic           w_col_match;

   scan_state_t    r_state,   w_state_nxt;
   logic [DW-1:0]  r_dwell,   w_dwell_nxt;
   logic [DBW-1:0] r_db,      w_db_nxt;
   logic [3:0]     r_rows,    w_rows_nxt;
   logic [1:0]     r_row_idx, w_row_idx_nxt;
   logic [3:0]     r_col,     w_col_nxt;
   logic [3:0]     r_code,    w_code_nxt;
   logic           r_valid,   w_valid_nxt;
   logic           r_held,    w_held_nxt;

   sync2 #(.W(5)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     ({stop, cout}),
      .o_q     (w_sync)
   );

   assign w_stop_s    = w_sync[4];
   assign w_cout_s    = w_sync[3:0];
   assign w_rows_rot  = {r_rows[2:0], r_rows[3]};
   assign w_col_match = (w_cout_s == r_col);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= SCAN;
         r_dwell   <= '0;
         r_db      <= '0;
         r_rows    <= ROW_INIT;
         r_row_idx <= 2'd0;
         r_col     <= 4'd0;
         r_code    <= 4'd0;
         r_valid   <= 1'b0;
         r_held    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_dwell   <= w_dwell_nxt;
         r_db      <= w_db_nxt;
         r_rows    <= w_rows_nxt;
         r_row_idx <= w_row_idx_nxt;
         r_col     <= w_col_nxt;
         r_code    <= w_code_nxt;
         r_valid   <= w_valid_nxt;
         r_held    <= w_held_nxt;
      end
   end

   // Every state change clears both counters, so neither ever wraps.
   always_comb begin
      w_state_nxt   = r_state;
      w_dwell_nxt   = r_dwell;
      w_db_nxt      = r_db;
      w_rows_nxt    = r_rows;
      w_row_idx_nxt = r_row_idx;
      w_col_nxt     = r_col;
      w_code_nxt    = r_code;
      w_valid_nxt   = 1'b0;
      w_held_nxt    = r_held;

      case (r_state)
         SCAN: begin
            if (r_dwell == DWELL_LAST) begin
               w_dwell_nxt = '0;
               if (w_stop_s) begin
                  // Row stays put: the column hit belongs to the row driven now.
                  w_state_nxt = PRESS_DB;
                  w_db_nxt    = '0;
                  w_col_nxt   = w_cout_s;
               end else begin
                  w_rows_nxt    = w_rows_rot;
                  w_row_idx_nxt = r_row_idx + 2'd1;
               end
            end else begin
               w_dwell_nxt = r_dwell + DW'(1);
            end
         end

         PRESS_DB: begin
            if (!w_stop_s || !w_col_match) begin
               w_state_nxt   = SCAN;
               w_dwell_nxt   = '0;
               w_db_nxt      = '0;
               w_rows_nxt    = w_rows_rot;
               w_row_idx_nxt = r_row_idx + 2'd1;
            end else if (r_db == DB_LAST) begin
               w_state_nxt = HELD;
               w_db_nxt    = '0;
               w_valid_nxt = 1'b1;
               w_code_nxt  = key_lookup(r_row_idx, r_col);
               w_held_nxt  = 1'b1;
            end else begin
               w_db_nxt = r_db + DBW'(1);
            end
         end

         HELD: begin
            if (!w_stop_s) begin
               w_state_nxt = RELEASE_DB;
               w_db_nxt    = '0;
            end
         end

         RELEASE_DB: begin
            if (w_stop_s) begin
               w_state_nxt = HELD;
               w_db_nxt    = '0;
            end else if (r_db == DB_LAST) begin
               w_state_nxt   = SCAN;
               w_db_nxt      = '0;
               w_dwell_nxt   = '0;
               w_held_nxt    = 1'b0;
               w_rows_nxt    = w_rows_rot;
               w_row_idx_nxt = r_row_idx + 2'd1;
            end else begin
               w_db_nxt = r_db + DBW'(1);
            end
         end

         default: begin
            w_state_nxt = SCAN;
         end
      endcase
   end

   assign rows      = r_rows;
   assign key_valid = r_valid;
   assign key_code  = r_code;
   assign key_held  = r_held;

endmodule
